// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, WB-to-ID operand bypass,
// flush bubble insertion and a saturating bubble counter.
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned OP_W       = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OP_W-1:0]       op_type_ID,
    input  logic [DATA_WIDTH-1:0] reg_read_data_1_ID,
    input  logic [DATA_WIDTH-1:0] reg_read_data_2_ID,
    input  logic [REG_AW-1:0]     read_register_1_ID,
    input  logic [REG_AW-1:0]     read_register_2_ID,
    input  logic [REG_AW-1:0]     reg_write_address_ID,
    input  logic                  reg_write_enable_ID,
    input  logic [DATA_WIDTH-1:0] extended_immi_ID,
    input  logic                  load_MEM,
    input  logic [REG_AW-1:0]     reg_write_address_MEM,
    input  logic                  reg_write_enable_WB,
    input  logic [REG_AW-1:0]     reg_write_address_WB,
    input  logic [DATA_WIDTH-1:0] reg_write_data,
    input  logic                  flush,
    output logic [OP_W-1:0]       op_type_EX,
    output logic [DATA_WIDTH-1:0] reg_read_data_1_EX,
    output logic [DATA_WIDTH-1:0] reg_read_data_2_EX,
    output logic [REG_AW-1:0]     read_register_1_EX,
    output logic [REG_AW-1:0]     read_register_2_EX,
    output logic [REG_AW-1:0]     reg_write_address_EX,
    output logic                  reg_write_enable_EX,
    output logic [DATA_WIDTH-1:0] extended_immi_EX,
    output logic                  stall,
    output logic [CNT_W-1:0]      bubble_count
);

    localparam logic [OP_W-1:0] OpAdd = OP_W'(1);
    localparam logic [OP_W-1:0] OpSub = OP_W'(2);
    localparam logic [OP_W-1:0] OpAnd = OP_W'(3);
    localparam logic [OP_W-1:0] OpOr  = OP_W'(4);
    localparam logic [OP_W-1:0] OpSlt = OP_W'(5);
    localparam logic [OP_W-1:0] OpLw  = OP_W'(6);
    localparam logic [OP_W-1:0] OpSw  = OP_W'(7);
    localparam logic [OP_W-1:0] OpBeq = OP_W'(8);

    function automatic logic uses_rs(input logic [OP_W-1:0] op);
        return (op >= OpAdd) && (op <= OpBeq);
    endfunction

    function automatic logic uses_rt(input logic [OP_W-1:0] op);
        return op inside {OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpSw, OpBeq};
    endfunction

    // True when the ID instruction reads dst, which a pending load has not yet produced.
    function automatic logic depends_on(input logic [OP_W-1:0]   op,
                                        input logic [REG_AW-1:0] rs,
                                        input logic [REG_AW-1:0] rt,
                                        input logic [REG_AW-1:0] dst);
        return (dst != '0) && ((uses_rs(op) && (rs == dst)) || (uses_rt(op) && (rt == dst)));
    endfunction

    logic hazard_ex;
    logic hazard_mem;
    logic load_bubble;
    logic fwd_1;
    logic fwd_2;
    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;

    assign hazard_ex = (op_type_EX == OpLw) && reg_write_enable_EX &&
                       depends_on(op_type_ID, read_register_1_ID, read_register_2_ID,
                                  reg_write_address_EX);
    assign hazard_mem = load_MEM &&
                        depends_on(op_type_ID, read_register_1_ID, read_register_2_ID,
                                   reg_write_address_MEM);

    assign stall       = (hazard_ex || hazard_mem) && !flush;
    assign load_bubble = flush || stall;

    assign fwd_1 = reg_write_enable_WB && (reg_write_address_WB != '0) &&
                   (reg_write_address_WB == read_register_1_ID);
    assign fwd_2 = reg_write_enable_WB && (reg_write_address_WB != '0) &&
                   (reg_write_address_WB == read_register_2_ID);

    assign operand_1 = fwd_1 ? reg_write_data : reg_read_data_1_ID;
    assign operand_2 = fwd_2 ? reg_write_data : reg_read_data_2_ID;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_type_EX           <= '0;
            reg_read_data_1_EX   <= '0;
            reg_read_data_2_EX   <= '0;
            read_register_1_EX   <= '0;
            read_register_2_EX   <= '0;
            reg_write_address_EX <= '0;
            reg_write_enable_EX  <= 1'b0;
            extended_immi_EX     <= '0;
            bubble_count         <= '0;
        end else if (load_bubble) begin
            op_type_EX           <= '0;
            reg_read_data_1_EX   <= '0;
            reg_read_data_2_EX   <= '0;
            read_register_1_EX   <= '0;
            read_register_2_EX   <= '0;
            reg_write_address_EX <= '0;
            reg_write_enable_EX  <= 1'b0;
            extended_immi_EX     <= '0;
            if (bubble_count != '1) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
        end else begin
            op_type_EX           <= op_type_ID;
            reg_read_data_1_EX   <= operand_1;
            reg_read_data_2_EX   <= operand_2;
            read_register_1_EX   <= read_register_1_ID;
            read_register_2_EX   <= read_register_2_ID;
            reg_write_address_EX <= reg_write_address_ID;
            reg_write_enable_EX  <= reg_write_enable_ID;
            extended_immi_EX     <= extended_immi_ID;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; a second instance with a 2-bit counter
// checks bubble-count saturation.
module tb_id_ex_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned OW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [OW-1:0] op_type_ID;
    logic [DW-1:0] rd1_ID, rd2_ID, imm_ID, wb_data;
    logic [AW-1:0] rs_ID, rt_ID, rd_ID, addr_MEM, addr_WB;
    logic          we_ID, load_MEM, we_WB, flush;

    logic [OW-1:0] op_EX, s_op_EX;
    logic [DW-1:0] rd1_EX, rd2_EX, imm_EX, s_rd1_EX, s_rd2_EX, s_imm_EX;
    logic [AW-1:0] rs_EX, rt_EX, rd_EX, s_rs_EX, s_rt_EX, s_rd_EX;
    logic          we_EX, stall, s_we_EX, s_stall;
    logic [15:0]   bc;
    logic [1:0]    s_bc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(DW), .REG_AW(AW), .OP_W(OW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .op_type_ID(op_type_ID),
        .reg_read_data_1_ID(rd1_ID), .reg_read_data_2_ID(rd2_ID),
        .read_register_1_ID(rs_ID), .read_register_2_ID(rt_ID),
        .reg_write_address_ID(rd_ID), .reg_write_enable_ID(we_ID),
        .extended_immi_ID(imm_ID), .load_MEM(load_MEM), .reg_write_address_MEM(addr_MEM),
        .reg_write_enable_WB(we_WB), .reg_write_address_WB(addr_WB),
        .reg_write_data(wb_data), .flush(flush),
        .op_type_EX(op_EX), .reg_read_data_1_EX(rd1_EX), .reg_read_data_2_EX(rd2_EX),
        .read_register_1_EX(rs_EX), .read_register_2_EX(rt_EX),
        .reg_write_address_EX(rd_EX), .reg_write_enable_EX(we_EX),
        .extended_immi_EX(imm_EX), .stall(stall), .bubble_count(bc)
    );

    id_ex_stage #(.DATA_WIDTH(DW), .REG_AW(AW), .OP_W(OW), .CNT_W(2)) sat (
        .clk(clk), .rst(rst), .op_type_ID(op_type_ID),
        .reg_read_data_1_ID(rd1_ID), .reg_read_data_2_ID(rd2_ID),
        .read_register_1_ID(rs_ID), .read_register_2_ID(rt_ID),
        .reg_write_address_ID(rd_ID), .reg_write_enable_ID(we_ID),
        .extended_immi_ID(imm_ID), .load_MEM(load_MEM), .reg_write_address_MEM(addr_MEM),
        .reg_write_enable_WB(we_WB), .reg_write_address_WB(addr_WB),
        .reg_write_data(wb_data), .flush(flush),
        .op_type_EX(s_op_EX), .reg_read_data_1_EX(s_rd1_EX), .reg_read_data_2_EX(s_rd2_EX),
        .read_register_1_EX(s_rs_EX), .read_register_2_EX(s_rt_EX),
        .reg_write_address_EX(s_rd_EX), .reg_write_enable_EX(s_we_EX),
        .extended_immi_EX(s_imm_EX), .stall(s_stall), .bubble_count(s_bc)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [OW-1:0] op, input logic [AW-1:0] rs,
                          input logic [AW-1:0] rt, input logic [AW-1:0] rd, input logic we,
                          input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                          input logic [DW-1:0] imm);
        op_type_ID = op; rs_ID = rs; rt_ID = rt; rd_ID = rd; we_ID = we;
        rd1_ID = d1; rd2_ID = d2; imm_ID = imm;
        #1;
    endtask

    task automatic clear_side;
        load_MEM = 1'b0; addr_MEM = '0; we_WB = 1'b0; addr_WB = '0; wb_data = '0;
        flush = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_side();
        set_id(4'd1, 5'd3, 5'd4, 5'd5, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if ({op_EX, rd1_EX, rd2_EX, rs_EX, rt_EX, rd_EX, we_EX, imm_EX} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: op=%0d rd1=%h rd2=%h rd=%0d we=%b imm=%h, want 0",
                         op_EX, rd1_EX, rd2_EX, rd_EX, we_EX, imm_EX);
            end
            n_vec++;
            if (bc !== 16'd0 || stall !== 1'b0) begin
                n_err++;
                $display("FAIL reset_bc_stall: bc=%0d stall=%b, want 0/0", bc, stall);
            end
        end
        rst = 1'b0;
        set_id(4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
    endtask

    task automatic test_load_use;
        set_id(4'd6, 5'd1, 5'd0, 5'd2, 1'b1, 32'h100, 32'd0, 32'd4);
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++; $display("FAIL lu_lw_nostall: stall=%b want 0", stall);
        end
        tick();
        n_vec++;
        if (op_EX !== 4'd6 || rd_EX !== 5'd2 || imm_EX !== 32'd4 || rd1_EX !== 32'h100) begin
            n_err++;
            $display("FAIL lu_lw_ex: op=%0d rd=%0d imm=%h rd1=%h want 6/2/4/100",
                     op_EX, rd_EX, imm_EX, rd1_EX);
        end
        set_id(4'd1, 5'd2, 5'd1, 5'd3, 1'b1, 32'hDEAD, 32'h10, 32'd0);
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++; $display("FAIL lu_stall1: stall=%b want 1", stall);
        end
        tick();
        n_vec++;
        if (op_EX !== 4'd0 || we_EX !== 1'b0 || bc !== 16'd1) begin
            n_err++; $display("FAIL lu_bubble1: op=%0d we=%b bc=%0d want 0/0/1", op_EX, we_EX, bc);
        end
        load_MEM = 1'b1; addr_MEM = 5'd2;
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++; $display("FAIL lu_stall2: stall=%b want 1", stall);
        end
        tick();
        n_vec++;
        if (op_EX !== 4'd0 || bc !== 16'd2) begin
            n_err++; $display("FAIL lu_bubble2: op=%0d bc=%0d want 0/2", op_EX, bc);
        end
        load_MEM = 1'b0; addr_MEM = 5'd0;
        we_WB = 1'b1; addr_WB = 5'd2; wb_data = 32'h0000_00A5;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++; $display("FAIL lu_release: stall=%b want 0", stall);
        end
        tick();
        n_vec++;
        if (op_EX !== 4'd1 || rd1_EX !== 32'h0000_00A5 || rd2_EX !== 32'h10 ||
            rd_EX !== 5'd3 || bc !== 16'd2) begin
            n_err++;
            $display("FAIL lu_add_ex: op=%0d rd1=%h rd2=%h rd=%0d bc=%0d want 1/a5/10/3/2",
                     op_EX, rd1_EX, rd2_EX, rd_EX, bc);
        end
        clear_side();
    endtask

    task automatic test_no_hazard;
        set_id(4'd6, 5'd1, 5'd0, 5'd2, 1'b1, 32'd0, 32'd0, 32'd0);
        tick();
        set_id(4'd9, 5'd2, 5'd2, 5'd0, 1'b0, 32'd0, 32'd0, 32'h40);
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++; $display("FAIL nh_jump: stall=%b want 0", stall);
        end
        tick();
        set_id(4'd6, 5'd1, 5'd0, 5'd0, 1'b1, 32'd0, 32'd0, 32'd0);
        tick();
        set_id(4'd1, 5'd0, 5'd0, 5'd3, 1'b1, 32'd0, 32'd0, 32'd0);
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++; $display("FAIL nh_r0_ex: stall=%b want 0", stall);
        end
        load_MEM = 1'b1; addr_MEM = 5'd0;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++; $display("FAIL nh_r0_mem: stall=%b want 0", stall);
        end
        tick();
        n_vec++;
        if (op_EX !== 4'd1 || bc !== 16'd2) begin
            n_err++; $display("FAIL nh_add_ex: op=%0d bc=%0d want 1/2", op_EX, bc);
        end
        clear_side();
    endtask

    task automatic test_bypass;
        set_id(4'd1, 5'd5, 5'd7, 5'd8, 1'b1, 32'h11, 32'h0BAD_0BAD, 32'd0);
        we_WB = 1'b1; addr_WB = 5'd7; wb_data = 32'h1234_5678;
        tick();
        n_vec++;
        if (rd2_EX !== 32'h1234_5678 || rd1_EX !== 32'h11) begin
            n_err++;
            $display("FAIL bp_r7: rd1=%h rd2=%h want 11/12345678", rd1_EX, rd2_EX);
        end
        set_id(4'd1, 5'd0, 5'd0, 5'd8, 1'b1, 32'd0, 32'd0, 32'd0);
        addr_WB = 5'd0; wb_data = 32'hFFFF_FFFF;
        tick();
        n_vec++;
        if (rd1_EX !== 32'd0 || rd2_EX !== 32'd0) begin
            n_err++; $display("FAIL bp_r0: rd1=%h rd2=%h want 0/0", rd1_EX, rd2_EX);
        end
        clear_side();
    endtask

    task automatic test_flush_reset;
        set_id(4'd6, 5'd1, 5'd0, 5'd4, 1'b1, 32'd0, 32'd0, 32'd0);
        tick();
        set_id(4'd2, 5'd4, 5'd1, 5'd6, 1'b1, 32'd9, 32'd9, 32'd0);
        n_vec++;
        if (stall !== 1'b1) begin
            n_err++; $display("FAIL fl_pre: stall=%b want 1", stall);
        end
        flush = 1'b1;
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            n_err++; $display("FAIL fl_stall: stall=%b want 0", stall);
        end
        tick();
        n_vec++;
        if (op_EX !== 4'd0 || rd_EX !== 5'd0 || bc !== 16'd3) begin
            n_err++; $display("FAIL fl_bubble: op=%0d rd=%0d bc=%0d want 0/0/3", op_EX, rd_EX, bc);
        end
        flush = 1'b0;
        set_id(4'd6, 5'd1, 5'd0, 5'd4, 1'b1, 32'd0, 32'd0, 32'd0);
        tick();
        set_id(4'd2, 5'd4, 5'd1, 5'd6, 1'b1, 32'd9, 32'd9, 32'd0);
        rst = 1'b1;
        tick();
        n_vec++;
        if (op_EX !== 4'd0 || we_EX !== 1'b0 || rd_EX !== 5'd0 || bc !== 16'd0 ||
            stall !== 1'b0) begin
            n_err++;
            $display("FAIL rst_midstall: op=%0d we=%b rd=%0d bc=%0d stall=%b want all 0",
                     op_EX, we_EX, rd_EX, bc, stall);
        end
        rst = 1'b0;
        set_id(4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic test_saturation;
        logic [1:0] exp_sat [5];
        exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3;
        exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (s_bc !== exp_sat[i] || bc !== 16'(i + 1)) begin
                n_err++;
                $display("FAIL sat_%0d: sat_bc=%0d bc=%0d want %0d/%0d",
                         i, s_bc, bc, exp_sat[i], i + 1);
            end
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_bypass();
        test_flush_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
